// File: rtl/cache_lru_victim_sel.sv
`default_nettype none
// ============================================================================
//  Module      : cache_lru_victim_sel
//  Description : True-LRU replacement tracker for a set-associative cache.
//                Keeps one recency order per set (slot 0 = MRU, slot
//                WAYS-1 = LRU), updates it on hits/refills and supplies a
//                one-hot victim way, preferring invalid ways. All sets are
//                swept to the identity order after reset.
//                Optional feature macro: LRU_LOCK_EN (adds lock_mask input;
//                locked ways are never chosen as victim).
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_lru_victim_sel #(
   parameter int WAYS     = 4,
   parameter int SETS     = 64,
   parameter int ADDR_W   = 32,
   parameter int INDEX_LO = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              touch_en,
   input  logic [WAYS-1:0]   touch_way,
   input  logic [WAYS-1:0]   valid_mask,
`ifdef LRU_LOCK_EN
   input  logic [WAYS-1:0]   lock_mask,
`endif
   output logic [WAYS-1:0]   victim_way,
   output logic              init_busy
);

   localparam int WB = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int IB = (SETS > 1) ? $clog2(SETS) : 1;

   typedef logic [WAYS-1:0][WB-1:0] order_t;

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [IB-1:0]   r_cnt;
   order_t          r_mem [SETS];

   logic [IB-1:0]   w_idx;
   order_t          w_order;
   order_t          w_ident;
   order_t          w_new;
   logic [WB-1:0]   w_tenc;
   logic [WB-1:0]   w_tpos;
   logic            w_tfound;
   logic            w_onehot;
   logic            w_touch_ok;
   logic [WAYS-1:0] w_victim;
   logic            w_unused_addr;

   // Only the index field of addr selects a set; other bits are don't-care.
   assign w_unused_addr = ^addr;
   assign w_idx         = addr[INDEX_LO+IB-1:INDEX_LO];
   assign w_order       = r_mem[w_idx];
   assign w_onehot      = (touch_way != '0) && ((touch_way & (touch_way - 1'b1)) == '0);
   assign w_touch_ok    = (r_state == ST_READY) && !rst && touch_en && w_onehot && w_tfound;

   // Identity order: slot k holds way WAYS-1-k, so way 0 starts as LRU.
   always_comb begin
      w_ident = '0;
      for (int k = 0; k < WAYS; k++) begin
         w_ident[k] = WB'(WAYS - 1 - k);
      end
   end

   // Encode the touched way and locate it in the current order, then build the
   // promoted order: touched way to slot 0, slots above it shift toward LRU.
   always_comb begin
      w_tenc   = '0;
      w_tpos   = '0;
      w_tfound = 1'b0;
      w_new    = w_order;
      for (int i = 0; i < WAYS; i++) begin
         if (touch_way[i]) begin
            w_tenc = WB'(i);
         end
      end
      for (int k = 0; k < WAYS; k++) begin
         if (!w_tfound && (w_order[k] == w_tenc)) begin
            w_tpos   = WB'(k);
            w_tfound = 1'b1;
         end
      end
      for (int k = 1; k < WAYS; k++) begin
         if (WB'(k) <= w_tpos) begin
            w_new[k] = w_order[k-1];
         end
      end
      w_new[0] = w_tenc;
   end

   // Victim selection from the pre-update order of the addressed set.
   always_comb begin
      logic f;
      w_victim = '0;
      f        = 1'b0;
`ifdef LRU_LOCK_EN
      for (int i = 0; i < WAYS; i++) begin
         if (!f && !valid_mask[i] && !lock_mask[i]) begin
            w_victim[i] = 1'b1;
            f           = 1'b1;
         end
      end
      for (int k = WAYS - 1; k >= 0; k--) begin
         if (!f && !lock_mask[w_order[k]]) begin
            w_victim[w_order[k]] = 1'b1;
            f                    = 1'b1;
         end
      end
`else
      for (int i = 0; i < WAYS; i++) begin
         if (!f && !valid_mask[i]) begin
            w_victim[i] = 1'b1;
            f           = 1'b1;
         end
      end
      if (!f) begin
         w_victim[w_order[WAYS-1]] = 1'b1;
      end
`endif
   end

   // State register and sweep counter; rst always restarts the sweep at set 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Next-state and status outputs.
   always_comb begin
      w_next     = r_state;
      init_busy  = 1'b0;
      victim_way = '0;
      case (r_state)
         ST_INIT: begin
            init_busy = 1'b1;
            if (r_cnt == IB'(SETS - 1)) begin
               w_next = ST_READY;
            end
         end
         ST_READY: begin
            victim_way = w_victim;
         end
         default: begin
            w_next = ST_INIT;
         end
      endcase
   end

   // Order storage: sweep writes identity, otherwise apply a valid touch.
   always_ff @(posedge clk) begin
      if (r_state == ST_INIT) begin
         r_mem[r_cnt] <= w_ident;
      end else if (w_touch_ok) begin
         r_mem[w_idx] <= w_new;
      end
   end

endmodule
`default_nettype wire
